game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clk cycles per countdown tick.
REQ-002 Parameter COUNT_TICKS, default 3: countdown length in ticks, range 1..7.
REQ-003 Parameter FLASH_CYC, default 12500000: clk cycles a judgement grade stays displayed.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 yellow_button / red_button / blue_button  in  1 each  debounced, synchronous button levels.
REQ-007 note_R_judge / note_B_judge  in  1 each  red/blue note present in judge column of shift_load.
REQ-008 offset  in  3  shift_load pixel phase, 0..6.
REQ-009 finish  in  1  shift_load song-end level.
REQ-010 song  out  2  song select to shift_load; 0 = none, 1..3 = song.
REQ-011 delete  out  1  one-cycle pulse clearing the judged note.
REQ-012 state  out  3  0 IDLE, 1 SELECT, 2 COUNTDOWN, 3 PLAY, 4 RESULT.
REQ-013 sel_song  out  2  song under selection, 1..3.
REQ-014 count_digit  out  3  countdown value shown to player.
REQ-015 grade  out  2  0 none, 1 PERFECT, 2 GOOD, 3 MISS.
REQ-016 score  out  16  accumulated score.
REQ-017 cur_combo / max_combo  out  8 each  current and best hit streak.
REQ-018 miss_cnt  out  8  missed notes plus wrong presses.

Function
REQ-019 The block SHALL detect button rising edges from a registered copy of each button; each edge SHALL act exactly once.
REQ-020 IDLE SHALL go to SELECT on a yellow edge; sel_song SHALL be set to 1.
REQ-021 In SELECT, a red edge SHALL advance sel_song 1->2->3->1, a blue edge SHALL step it 3->2->1->3, and a yellow edge SHALL go to COUNTDOWN.
REQ-022 COUNTDOWN SHALL load count_digit=COUNT_TICKS, decrement it every TICK_DIV cycles, and go to PLAY in the cycle after the tick at which count_digit reaches 0.
REQ-023 song SHALL equal sel_song in PLAY only and 0 in every other state.
REQ-024 Entry to PLAY SHALL clear score, cur_combo, max_combo, miss_cnt and grade; state SHALL be held in PLAY until finish is high.
REQ-025 In PLAY, a red edge with note_R_judge=1, or a blue edge with note_B_judge=1, and no hit lock SHALL be a hit.
REQ-026 Hit timing SHALL be offset 2..4 -> PERFECT (+3 score); offset 0,1,5,6 -> GOOD (+1 score).
REQ-027 On a hit, delete SHALL pulse high for exactly the following cycle, cur_combo SHALL increment (saturate 255), and max_combo SHALL update to max(max_combo, new cur_combo).
REQ-028 A hit SHALL set a hit lock, cleared when offset goes 6->0; while locked, presses SHALL be ignored, with no score and no miss.
REQ-029 A red or blue edge with the matching judge input low, or red and blue edges in the same cycle, SHALL be a wrong press: MISS, miss_cnt+1, cur_combo=0, no delete.
REQ-030 When offset goes 6->0 with note_R_judge or note_B_judge high and no hit lock, the event SHALL count as a passed note: MISS, miss_cnt+1, cur_combo=0.
REQ-031 A hit and a passed-note miss in the same cycle SHALL count as the hit only.
REQ-032 score SHALL saturate at 16'hFFFF; miss_cnt SHALL saturate at 255.
REQ-033 grade SHALL be held FLASH_CYC cycles after each judgement, then return to 0; a new judgement SHALL overwrite the grade and restart the hold.
REQ-034 A finish rising edge in PLAY SHALL go to RESULT; score, combo and miss values SHALL then be frozen.
REQ-035 RESULT SHALL go to IDLE on a yellow edge; the frozen values SHALL be kept until the next PLAY entry.
REQ-036 Undefined state encodings SHALL go to IDLE.

Reset
REQ-037 rst high SHALL force IDLE immediately in any state; all counters, locks and edge registers SHALL be cleared.
REQ-038 Reset values: song=0, delete=0, state=0, sel_song=1, count_digit=0, grade=0, score=0, cur_combo=0, max_combo=0, miss_cnt=0.
REQ-039 Reset asserted mid-PLAY SHALL drop song to 0 asynchronously.

Verification (TICK_DIV=4, COUNT_TICKS=3, FLASH_CYC=8)
REQ-040 Yellow, red, red, yellow edges -> sel_song=3; count_digit 3,2,1,0 at 4-cycle spacing; then state=3 and song=3.
REQ-041 In PLAY, note_R_judge=1, offset=3, red edge -> delete pulses 1 cycle, score=3, cur_combo=1, grade=1 for 8 cycles.
REQ-042 Second red edge before offset wraps -> no score change, no delete; offset 6->0 with note_R_judge still 1 -> no miss.
REQ-043 Blue edge while only note_R_judge=1 -> miss_cnt=1, cur_combo=0, max_combo unchanged; note passes offset 6->0 unhit -> miss_cnt=2.
REQ-044 finish rises with score=7 -> state=4, song=0, score frozen at 7; yellow edge -> state=0, score still 7.
REQ-045 rst asserted mid-PLAY -> song=0 and all outputs at reset values with no clock edge required.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game flow controller: song select, countdown, note judgement and scoring,
// result freeze. Drives shift_load's song select and note delete.
module game_flow_ctrl #(
  parameter int TICK_DIV    = 25000000,
  parameter int COUNT_TICKS = 3,
  parameter int FLASH_CYC   = 12500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        yellow_button,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic [1:0]  song,
  output logic        delete,
  output logic [2:0]  state,
  output logic [1:0]  sel_song,
  output logic [2:0]  count_digit,
  output logic [1:0]  grade,
  output logic [15:0] score,
  output logic [7:0]  cur_combo,
  output logic [7:0]  max_combo,
  output logic [7:0]  miss_cnt
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_COUNTDOWN = 3'd2,
    S_PLAY      = 3'd3,
    S_RESULT    = 3'd4
  } state_t;

  state_t cur_st, nxt_st;

  logic          yellow_q, red_q, blue_q, finish_q;
  logic [2:0]    offset_q;
  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] flash_cnt;
  logic          hit_lock;

  logic yellow_e, red_e, blue_e, finish_e;
  logic in_play, play_entry, wrap, press_ok, wrong_press, hit, passed, miss_ev, perfect;
  logic [16:0] score_sum;
  logic [15:0] score_next;
  logic [7:0]  combo_inc;

  assign yellow_e = yellow_button & ~yellow_q;
  assign red_e    = red_button    & ~red_q;
  assign blue_e   = blue_button   & ~blue_q;
  assign finish_e = finish        & ~finish_q;

  assign in_play    = (cur_st == S_PLAY);
  assign play_entry = (cur_st == S_COUNTDOWN) && (count_digit == 3'd0);
  assign wrap       = (offset_q == 3'd6) && (offset == 3'd0);
  assign perfect    = (offset >= 3'd2) && (offset <= 3'd4);

  // Presses are only judged while unlocked; a locked press is silently dropped.
  assign press_ok    = in_play & ~hit_lock & (red_e | blue_e);
  assign wrong_press = press_ok & ((red_e & blue_e) | (red_e & ~note_R_judge) | (blue_e & ~note_B_judge));
  assign hit         = press_ok & ~wrong_press;
  assign passed      = in_play & wrap & (note_R_judge | note_B_judge) & ~hit_lock & ~hit;
  assign miss_ev     = wrong_press | passed;

  assign score_sum  = {1'b0, score} + (perfect ? 17'd3 : 17'd1);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign combo_inc  = (cur_combo == 8'hFF) ? 8'hFF : cur_combo + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_st <= S_IDLE;
    else     cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      S_IDLE:      if (yellow_e) nxt_st = S_SELECT;
      S_SELECT:    if (yellow_e) nxt_st = S_COUNTDOWN;
      S_COUNTDOWN: if (count_digit == 3'd0) nxt_st = S_PLAY;
      S_PLAY:      if (finish_e) nxt_st = S_RESULT;
      S_RESULT:    if (yellow_e) nxt_st = S_IDLE;
      default:     nxt_st = S_IDLE;
    endcase
  end

  always_comb begin
    state = cur_st;
    song  = '0;
    if (cur_st == S_PLAY) song = sel_song;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yellow_q    <= 1'b0;
      red_q       <= 1'b0;
      blue_q      <= 1'b0;
      finish_q    <= 1'b0;
      offset_q    <= '0;
      sel_song    <= 2'd1;
      count_digit <= '0;
      tick_cnt    <= '0;
    end else begin
      yellow_q <= yellow_button;
      red_q    <= red_button;
      blue_q   <= blue_button;
      finish_q <= finish;
      offset_q <= offset;
      case (cur_st)
        S_IDLE: if (yellow_e) sel_song <= 2'd1;
        S_SELECT: begin
          if (yellow_e) begin
            count_digit <= 3'(COUNT_TICKS);
            tick_cnt    <= '0;
          end else if (red_e) begin
            sel_song <= (sel_song == 2'd3) ? 2'd1 : sel_song + 2'd1;
          end else if (blue_e) begin
            sel_song <= (sel_song == 2'd1) ? 2'd3 : sel_song - 2'd1;
          end
        end
        S_COUNTDOWN: begin
          if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
            if (count_digit != 3'd0) count_digit <= count_digit - 3'd1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      delete    <= 1'b0;
      grade     <= '0;
      flash_cnt <= '0;
      score     <= '0;
      cur_combo <= '0;
      max_combo <= '0;
      miss_cnt  <= '0;
      hit_lock  <= 1'b0;
    end else begin
      delete <= hit;
      if (play_entry) begin
        grade     <= '0;
        flash_cnt <= '0;
        score     <= '0;
        cur_combo <= '0;
        max_combo <= '0;
        miss_cnt  <= '0;
        hit_lock  <= 1'b0;
      end else if (hit) begin
        score     <= score_next;
        cur_combo <= combo_inc;
        if (combo_inc > max_combo) max_combo <= combo_inc;
        grade     <= perfect ? 2'd1 : 2'd2;
        flash_cnt <= FW'(FLASH_CYC - 1);
        hit_lock  <= 1'b1;
      end else begin
        if (miss_ev) begin
          miss_cnt  <= (miss_cnt == 8'hFF) ? 8'hFF : miss_cnt + 8'd1;
          cur_combo <= '0;
          grade     <= 2'd3;
          flash_cnt <= FW'(FLASH_CYC - 1);
        end else if (grade != 2'd0) begin
          if (flash_cnt == '0) grade <= '0;
          else                 flash_cnt <= flash_cnt - 1'b1;
        end
        if (wrap) hit_lock <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game flow plus randomized play phase
// checked every cycle against a behavioural game model.
module tb_game_flow_ctrl;
  localparam int TICK  = 4;
  localparam int COUNT = 3;
  localparam int FLASH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        yellow_button, red_button, blue_button;
  logic        note_R_judge, note_B_judge;
  logic [2:0]  offset;
  logic        finish;
  logic [1:0]  song;
  logic        delete;
  logic [2:0]  state;
  logic [1:0]  sel_song;
  logic [2:0]  count_digit;
  logic [1:0]  grade;
  logic [15:0] score;
  logic [7:0]  cur_combo, max_combo, miss_cnt;

  int checks = 0;
  int failures = 0;

  // model state
  int m_state, m_sel, m_digit, m_tick, m_score, m_cur, m_max, m_miss;
  int m_grade, m_gleft, m_lock, m_del;
  int p_y, p_r, p_b, p_f, p_off;

  game_flow_ctrl #(.TICK_DIV(TICK), .COUNT_TICKS(COUNT), .FLASH_CYC(FLASH)) dut (
    .clk(clk), .rst(rst),
    .yellow_button(yellow_button), .red_button(red_button), .blue_button(blue_button),
    .note_R_judge(note_R_judge), .note_B_judge(note_B_judge),
    .offset(offset), .finish(finish),
    .song(song), .delete(delete), .state(state), .sel_song(sel_song),
    .count_digit(count_digit), .grade(grade), .score(score),
    .cur_combo(cur_combo), .max_combo(max_combo), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_sel = 1; m_digit = 0; m_tick = 0;
    m_score = 0; m_cur = 0; m_max = 0; m_miss = 0;
    m_grade = 0; m_gleft = 0; m_lock = 0; m_del = 0;
    p_y = 0; p_r = 0; p_b = 0; p_f = 0; p_off = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_song"}, int'(song), 0);
    chk({tag, "_delete"}, int'(delete), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_sel"}, int'(sel_song), 1);
    chk({tag, "_digit"}, int'(count_digit), 0);
    chk({tag, "_grade"}, int'(grade), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_cur"}, int'(cur_combo), 0);
    chk({tag, "_max"}, int'(max_combo), 0);
    chk({tag, "_miss"}, int'(miss_cnt), 0);
  endtask

  // Applies the game rules to the inputs present before the coming clock edge.
  task automatic model_update();
    int ye, re, be, fe, pts, judged, wrong, hitv, wrap, passed;
    ye = (yellow_button && !p_y); re = (red_button && !p_r);
    be = (blue_button && !p_b);   fe = (finish && !p_f);
    m_del = 0; judged = 0;
    case (m_state)
      0: if (ye != 0) begin m_state = 1; m_sel = 1; end
      1: begin
        if (ye != 0) begin m_state = 2; m_digit = COUNT; m_tick = 0; end
        else if (re != 0) m_sel = m_sel % 3 + 1;
        else if (be != 0) m_sel = (m_sel + 1) % 3 + 1;
      end
      2: begin
        if (m_digit == 0) begin
          m_state = 3; m_score = 0; m_cur = 0; m_max = 0; m_miss = 0;
          m_grade = 0; m_gleft = 0; m_lock = 0;
        end else begin
          m_tick++;
          if (m_tick == TICK) begin m_tick = 0; m_digit--; end
        end
      end
      3: begin
        wrap = (p_off == 6 && offset == 0);
        wrong = 0; hitv = 0;
        if (m_lock == 0 && (re != 0 || be != 0)) begin
          if ((re != 0 && be != 0) || (re != 0 && !note_R_judge) || (be != 0 && !note_B_judge))
            wrong = 1;
          else
            hitv = 1;
        end
        passed = (wrap != 0 && (note_R_judge || note_B_judge) && m_lock == 0 && hitv == 0);
        if (hitv != 0) begin
          pts = (offset >= 2 && offset <= 4) ? 3 : 1;
          m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
          m_cur = (m_cur < 255) ? m_cur + 1 : 255;
          if (m_cur > m_max) m_max = m_cur;
          m_del = 1; m_grade = (pts == 3) ? 1 : 2; m_gleft = FLASH; judged = 1; m_lock = 1;
        end else begin
          if (wrong != 0 || passed != 0) begin
            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
            m_cur = 0; m_grade = 3; m_gleft = FLASH; judged = 1;
          end
          if (wrap != 0) m_lock = 0;
        end
        if (fe != 0) m_state = 4;
      end
      default: if (ye != 0) m_state = 0;
    endcase
    if (judged == 0 && m_gleft > 0) begin
      m_gleft--;
      if (m_gleft == 0) m_grade = 0;
    end
    p_y = yellow_button; p_r = red_button; p_b = blue_button; p_f = finish; p_off = offset;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("state", int'(state), m_state);
    chk("song", int'(song), (m_state == 3) ? m_sel : 0);
    chk("sel_song", int'(sel_song), m_sel);
    chk("count_digit", int'(count_digit), m_digit);
    chk("delete", int'(delete), m_del);
    chk("grade", int'(grade), m_grade);
    chk("score", int'(score), m_score);
    chk("cur_combo", int'(cur_combo), m_cur);
    chk("max_combo", int'(max_combo), m_max);
    chk("miss_cnt", int'(miss_cnt), m_miss);
  endtask

  initial begin
    int n, off;
    rst = 1'b1;
    yellow_button = 0; red_button = 0; blue_button = 0;
    note_R_judge = 0; note_B_judge = 0; offset = 3'd0; finish = 0;
    model_reset();
    #3;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    // select song 3 and count down
    yellow_button = 1; step(); yellow_button = 0; step();
    red_button = 1; step(); red_button = 0; step();
    red_button = 1; step(); red_button = 0; step();
    chk("sel_is_3", int'(sel_song), 3);
    yellow_button = 1; step();
    chk("cd_load", int'(count_digit), 3);
    yellow_button = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 0) chk("cd_tick", int'(count_digit), 3 - k / 4);
      else chk("cd_state", int'(state), 2);
    end
    step();
    chk("play_state", int'(state), 3);
    chk("play_song", int'(song), 3);

    // perfect hit, then a locked press and a locked wrap
    note_R_judge = 1; offset = 3'd3; step();
    red_button = 1; step();
    chk("hit_delete", int'(delete), 1);
    chk("hit_score", int'(score), 3);
    chk("hit_combo", int'(cur_combo), 1);
    chk("hit_grade", int'(grade), 1);
    for (int k = 1; k <= 7; k++) begin
      red_button = (k == 2);
      step();
      chk("grade_hold", int'(grade), 1);
      chk("lock_del", int'(delete), 0);
      chk("lock_score", int'(score), 3);
    end
    red_button = 0; step();
    chk("grade_expire", int'(grade), 0);
    offset = 3'd6; step(); offset = 3'd0; step();
    chk("locked_wrap", int'(miss_cnt), 0);

    // wrong press, then an unhit note passes
    offset = 3'd1; blue_button = 1; step();
    chk("wrong_miss", int'(miss_cnt), 1);
    chk("wrong_combo", int'(cur_combo), 0);
    chk("wrong_max", int'(max_combo), 1);
    chk("wrong_grade", int'(grade), 3);
    chk("wrong_del", int'(delete), 0);
    blue_button = 0; step();
    offset = 3'd6; step(); offset = 3'd0; step();
    chk("pass_miss", int'(miss_cnt), 2);

    // bring score to 7 with a perfect and a good hit
    offset = 3'd3; red_button = 1; step(); red_button = 0; step();
    offset = 3'd6; step(); note_R_judge = 0; offset = 3'd0; step();
    offset = 3'd5; note_B_judge = 1; blue_button = 1; step(); blue_button = 0; step();
    chk("good_score", int'(score), 7);
    offset = 3'd6; step(); note_B_judge = 0; offset = 3'd0; step();
    chk("combo_2", int'(max_combo), 2);

    finish = 1; step();
    chk("result_state", int'(state), 4);
    chk("result_song", int'(song), 0);
    note_R_judge = 1; offset = 3'd3; red_button = 1; step(); red_button = 0; step();
    chk("frozen_score", int'(score), 7);
    yellow_button = 1; step(); yellow_button = 0; finish = 0; note_R_judge = 0; step();
    chk("idle_state", int'(state), 0);
    chk("idle_score", int'(score), 7);

    // second game with randomized selection and play
    yellow_button = 1; step(); yellow_button = 0; step();
    for (int k = 0; k < 6; k++) begin
      red_button = ($urandom % 2 == 0); blue_button = ($urandom % 2 == 0); step();
    end
    red_button = 0; blue_button = 0; step();
    yellow_button = 1; step(); yellow_button = 0;
    n = 0;
    while (m_state != 3 && n < 40) begin step(); n++; end
    chk("play_reach", int'(state), 3);
    off = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom % 3 == 0) off = (off + 1) % 7;
      offset = 3'(off);
      note_R_judge = ($urandom % 3 == 0);
      note_B_judge = ($urandom % 3 == 0);
      red_button = ($urandom % 4 == 0);
      blue_button = ($urandom % 4 == 0);
      step();
    end

    // asynchronous reset in the middle of play
    red_button = 0; blue_button = 0; note_R_judge = 0; note_B_judge = 0; offset = 3'd0;
    chk("pre_rst_song", int'(song), m_sel);
    #1 rst = 1'b1;
    #2;
    chk_reset_vals("async_rst");
    #1 rst = 1'b0;
    model_reset();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
